// File: rtl/de10lite_sw_debounce.sv
// ---------------------------------------------------------------------------------------------
// de10lite_sw_debounce
//
// Purpose:
//   Conditions the DE10-Lite slide switches and push keys before they reach the switch PIO.
//   Each raw input first passes through a two-flop synchroniser. One shared prescaler then
//   produces a slow sample tick. On every tick each bit's synchronised level is pushed into
//   a short history. A new debounced level is accepted only when the last SAMPLES tick
//   samples, the current one included, all agree. Accepted transitions also produce
//   one-cycle rise/fall pulses and a summary any_change pulse.
//
// Parameters:
//   WIDTH        number of switch/key inputs conditioned (default 19)
//   TICK_CYCLES  clk cycles per sample tick, 1..2^24 (default 50000 = 1 ms at 50 MHz)
//   SAMPLES      consecutive equal samples needed to accept a level, 2..16 (default 8)
//
// Ports:
//   clk          sole clock, all state on its rising edge
//   reset        asynchronous active-high reset (release is synchronised externally)
//   sw_raw       raw asynchronous switch levels
//   sw_out       debounced levels (registered)
//   rise         one-cycle pulse per bit on an accepted 0->1 transition (registered)
//   fall         one-cycle pulse per bit on an accepted 1->0 transition (registered)
//   any_change   one-cycle pulse when any bit of rise or fall pulses (registered)
//   tick         one-cycle sample-tick strobe, for diagnostics
//
// No output has a combinational path from sw_raw.
// ---------------------------------------------------------------------------------------------
module de10lite_sw_debounce #(
    parameter int unsigned WIDTH       = 19,
    parameter int unsigned TICK_CYCLES = 50000,
    parameter int unsigned SAMPLES     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change,
    output logic             tick
);

    // A counter of at least one bit keeps TICK_CYCLES == 1 legal. In that case it stays at
    // 0, which is also the terminal count, so every cycle is a tick.
    localparam int unsigned     CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    // -----------------------------------------------------------------------------------------
    // Input synchroniser
    // -----------------------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Shared sample-tick prescaler
    // -----------------------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_hit;
    logic             w_tick;

    assign w_cnt_hit = (r_cnt == CNT_MAX);
    // Gating with reset keeps tick low during reset even when TICK_CYCLES == 1. In that
    // configuration the counter already sits at its terminal count.
    assign w_tick    = w_cnt_hit & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Sample history
    // -----------------------------------------------------------------------------------------
    // The history is stored as SAMPLES-1 whole-width vectors. r_hist[0] holds the most recent
    // tick sample and r_hist[SAMPLES-2] the oldest. Each bit column is that bit's history.
    logic [WIDTH-1:0] r_hist [SAMPLES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SAMPLES - 1; k++) begin
                r_hist[k] <= '0;
            end
        end else if (w_tick) begin
            r_hist[0] <= r_sync2;
            for (int unsigned k = 1; k < SAMPLES - 1; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Acceptance and next-state logic
    // -----------------------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sw_out;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_any;

    logic [WIDTH-1:0] w_all1;
    logic [WIDTH-1:0] w_all0;
    logic [WIDTH-1:0] w_rise_d;
    logic [WIDTH-1:0] w_fall_d;
    logic [WIDTH-1:0] w_sw_out_d;
    logic             w_any_d;

    always_comb begin
        // The window is the stored history plus the current synchronised sample.
        w_all1 = r_sync2;
        w_all0 = ~r_sync2;
        for (int unsigned k = 0; k < SAMPLES - 1; k++) begin
            w_all1 = w_all1 & r_hist[k];
            w_all0 = w_all0 & ~r_hist[k];
        end

        w_rise_d = '0;
        w_fall_d = '0;
        if (w_tick) begin
            // A bit can only rise while low and only fall while high, so rise and fall for
            // the same bit are mutually exclusive.
            w_rise_d = w_all1 & ~r_sw_out;
            w_fall_d = w_all0 & r_sw_out;
        end

        w_sw_out_d = (r_sw_out | w_rise_d) & ~w_fall_d;
        w_any_d    = |(w_rise_d | w_fall_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_out <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_any    <= 1'b0;
        end else begin
            r_sw_out <= w_sw_out_d;
            r_rise   <= w_rise_d;
            r_fall   <= w_fall_d;
            r_any    <= w_any_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign sw_out     = r_sw_out;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_change = r_any;
    assign tick       = w_tick;

endmodule

// File: tb/tb_de10lite_sw_debounce.sv
// Testbench for de10lite_sw_debounce with TICK_CYCLES=4, SAMPLES=3 and WIDTH=19.
module tb_de10lite_sw_debounce;

    localparam int W  = 19;
    localparam int TC = 4;
    localparam int S  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_change;
    logic         tick;

    de10lite_sw_debounce #(
        .WIDTH       (W),
        .TICK_CYCLES (TC),
        .SAMPLES     (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_out     (sw_out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------------------------
    // Reference model.
    // Each bit keeps its last tick sample and the length of the current run of equal samples.
    // A level is accepted once the run reaches S. Reset leaves an implied run of S-1 zeros.
    // The sample seen at an edge is the raw value that was present two edges earlier.
    // ------------------------------------------------------------------------------------------
    logic [W-1:0] m_out, m_rise, m_fall, m_last;
    logic         m_any;
    int           m_cnt;
    int           m_run [W];
    logic [W-1:0] m_q [$];

    task automatic model_reset();
        m_cnt  = 0;
        m_out  = '0;
        m_rise = '0;
        m_fall = '0;
        m_any  = 1'b0;
        m_last = '0;
        for (int i = 0; i < W; i++) m_run[i] = S - 1;
        m_q.delete();
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] samp;
        m_rise = '0;
        m_fall = '0;
        if (m_cnt == TC - 1) begin
            samp = (m_q.size() == 2) ? m_q[0] : '0;
            for (int i = 0; i < W; i++) begin
                if (samp[i] == m_last[i]) begin
                    if (m_run[i] < 16) m_run[i]++;
                end else begin
                    m_run[i]  = 1;
                    m_last[i] = samp[i];
                end
                if (m_run[i] >= S && samp[i] != m_out[i]) begin
                    m_out[i] = samp[i];
                    if (samp[i]) m_rise[i] = 1'b1;
                    else         m_fall[i] = 1'b1;
                end
            end
        end
        m_any = |(m_rise | m_fall);
        m_cnt = (m_cnt + 1) % TC;
        m_q.push_back(raw);
        if (m_q.size() > 2) void'(m_q.pop_front());
    endtask

    task automatic model_check();
        chk("sw_out", sw_out, m_out);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk_int("any_change", int'(any_change), int'(m_any));
        chk_int("tick", int'(tick), (m_cnt == TC - 1 && !reset) ? 1 : 0);
    endtask

    // Drive one cycle of raw input, advance through the edge and check the model.
    task automatic step(input logic [W-1:0] raw);
        sw_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        model_check();
    endtask

    // Leaves the bench 1 time unit after a posedge with reset released (cycle 0).
    task automatic do_reset();
        reset  = 1'b1;
        sw_raw = '0;
        #1;
        model_reset();
        model_check();
        repeat (2) @(posedge clk);
        #1;
        model_check();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------------------------------
    // Directed table: bit 0 rises and then falls. Each record covers cycles c0..c1.
    // ------------------------------------------------------------------------------------------
    typedef struct {
        int           c0;
        int           c1;
        logic [W-1:0] raw;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         any;
    } seg_t;

    seg_t tbl [6];

    initial begin
        int           k;
        int           pulses;
        int           ticks;
        int           first_tick;
        logic [W-1:0] raw;
        logic         seen5;

        tbl[0] = '{c0: 0,  c1: 11, raw: 19'h1, out: 19'h0, rise: 19'h0, fall: 19'h0, any: 1'b0};
        tbl[1] = '{c0: 12, c1: 12, raw: 19'h1, out: 19'h1, rise: 19'h1, fall: 19'h0, any: 1'b1};
        tbl[2] = '{c0: 13, c1: 15, raw: 19'h1, out: 19'h1, rise: 19'h0, fall: 19'h0, any: 1'b0};
        tbl[3] = '{c0: 16, c1: 27, raw: 19'h0, out: 19'h1, rise: 19'h0, fall: 19'h0, any: 1'b0};
        tbl[4] = '{c0: 28, c1: 28, raw: 19'h0, out: 19'h0, rise: 19'h0, fall: 19'h1, any: 1'b1};
        tbl[5] = '{c0: 29, c1: 35, raw: 19'h0, out: 19'h0, rise: 19'h0, fall: 19'h0, any: 1'b0};

        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int c = tbl[s].c0; c <= tbl[s].c1; c++) begin
                chk($sformatf("tbl_c%0d_out", c), sw_out, tbl[s].out);
                chk($sformatf("tbl_c%0d_rise", c), rise, tbl[s].rise);
                chk($sformatf("tbl_c%0d_fall", c), fall, tbl[s].fall);
                chk_int($sformatf("tbl_c%0d_any", c), int'(any_change), int'(tbl[s].any));
                chk_int($sformatf("tbl_c%0d_tick", c), int'(tick), (c % TC == TC - 1) ? 1 : 0);
                step(tbl[s].raw);
            end
        end

        // Quiet inputs: no pulses, and a tick every 4th cycle starting at cycle 3.
        do_reset();
        pulses     = 0;
        ticks      = 0;
        first_tick = -1;
        for (int c = 1; c <= 100; c++) begin
            step('0);
            if (rise != 0 || fall != 0 || any_change) pulses++;
            if (tick) begin
                ticks++;
                if (first_tick < 0) first_tick = c;
            end
        end
        chk_int("quiet_pulses", pulses, 0);
        chk_int("quiet_ticks", ticks, 25);
        chk_int("quiet_first_tick", first_tick, 3);
        chk("quiet_out", sw_out, '0);

        // A five-cycle pulse on bit 5 is too short to be accepted.
        do_reset();
        seen5  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            step((c < 5) ? 19'h20 : 19'h0);
            if (sw_out[5]) seen5 = 1'b1;
            if (rise != 0 || fall != 0 || any_change) pulses++;
        end
        chk_int("short_out5", int'(seen5), 0);
        chk_int("short_pulses", pulses, 0);

        // All bits go high together and are accepted on the same edge.
        do_reset();
        k = 0;
        step(19'h7FFFF);
        k++;
        while (rise == 0 && k < 40) begin
            step(19'h7FFFF);
            k++;
        end
        chk_int("all_latency", k, 12);
        chk("all_rise", rise, 19'h7FFFF);
        chk("all_out", sw_out, 19'h7FFFF);
        chk_int("all_any", int'(any_change), 1);
        step(19'h7FFFF);
        chk("all_rise_end", rise, 19'h0);
        chk_int("all_any_end", int'(any_change), 0);

        // Bit 3 chatters with a period of two ticks and must never be accepted.
        do_reset();
        pulses = 0;
        seen5  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            step(((c / 4) % 2 == 1) ? 19'h8 : 19'h0);
            if (sw_out[3]) seen5 = 1'b1;
            if (rise != 0 || fall != 0 || any_change) pulses++;
        end
        chk_int("chatter_out3", int'(seen5), 0);
        chk_int("chatter_pulses", pulses, 0);

        // Reset asserted during the rise pulse clears everything at once. The held switch is
        // then reported again after three ticks.
        do_reset();
        k = 0;
        while (!rise[2] && k < 40) begin
            step(19'h4);
            k++;
        end
        chk_int("rst_first_latency", k, 12);
        reset = 1'b1;
        #1;
        chk("rst_mid_out", sw_out, '0);
        chk("rst_mid_rise", rise, '0);
        chk_int("rst_mid_any", int'(any_change), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        while (!rise[2] && k < 40) begin
            step(19'h4);
            k++;
        end
        chk_int("rst_re_latency", k, 12);

        // Random traffic: bits flip occasionally, with rare bursts and rare resets.
        do_reset();
        raw = '0;
        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, 15);
            if (k == 0)     raw = W'($urandom);
            else if (k < 4) raw[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                step(raw);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
